// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and element/accumulator types.
package cnn_pkg;
    localparam int DATA_W   = 8;
    localparam int ACC_W    = 20;
    localparam int NUM_TAPS = 9;

    typedef logic signed [DATA_W-1:0] elem_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
endpackage

// File: rtl/sat_requant.sv
// Requantiser: optional ReLU, floor arithmetic shift, saturation to DATA_W.
// Build option: CONV_PE_RELU_EN clamps negative accumulators to zero first.
module sat_requant
    import cnn_pkg::*;
#(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int ACC_W  = cnn_pkg::ACC_W,
    parameter int SHIFT  = 4
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic signed [DATA_W-1:0] o_data
);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (DATA_W - 1)));

    logic signed [ACC_W-1:0] w_pre;
    logic signed [ACC_W-1:0] w_shifted;

    always_comb begin
`ifdef CONV_PE_RELU_EN
        w_pre = i_acc[ACC_W-1] ? '0 : i_acc;
`else
        w_pre = i_acc;
`endif
        w_shifted = w_pre >>> SHIFT;
        if (w_shifted > SAT_MAX) begin
            o_data = SAT_MAX[DATA_W-1:0];
        end else if (w_shifted < SAT_MIN) begin
            o_data = SAT_MIN[DATA_W-1:0];
        end else begin
            o_data = w_shifted[DATA_W-1:0];
        end
    end
endmodule

// File: rtl/conv3x3_pe.sv
// 3x3 convolution processing element: multiply, accumulate+bias, requantise.
// Three pipeline stages stall together; CONV_PE_RELU_EN selects fused ReLU.
module conv3x3_pe
    import cnn_pkg::*;
#(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int ACC_W  = cnn_pkg::ACC_W,
    parameter int SHIFT  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_TAPS-1:0][DATA_W-1:0]    ifm_in,
    input  logic [NUM_TAPS-1:0][DATA_W-1:0]    wgt_in,
    input  logic signed [DATA_W-1:0]           bias_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [DATA_W-1:0]           out_data,
    output logic [15:0]                        out_cnt
);
    // Handshake: a window transfers on in_valid && in_ready; a result on
    // out_valid && out_ready. The whole pipe moves only when S3 can drain.
    logic w_advance;

    logic r_s1_valid;
    logic r_s2_valid;
    logic r_s3_valid;

    logic signed [2*DATA_W-1:0] r_prod [NUM_TAPS];
    logic signed [DATA_W-1:0]   r_s1_bias;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    r_s2_acc;
    logic signed [DATA_W-1:0]   w_requant;
    logic signed [DATA_W-1:0]   r_out_data;
    logic [15:0]                r_cnt;

    assign w_advance = !r_s3_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_s3_valid;
    assign out_data  = r_out_data;
    assign out_cnt   = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_out_data <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_data <= w_requant;
            end
        end
    end

    // Datapath registers carry no reset; the valid flags qualify them.
    always_ff @(posedge clk) begin
        if (w_advance && in_valid) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_prod[i] <= $signed(ifm_in[i]) * $signed(wgt_in[i]);
            end
            r_s1_bias <= bias_in;
        end
        if (w_advance && r_s1_valid) begin
            r_s2_acc <= w_sum;
        end
    end

    always_comb begin
        w_sum = ACC_W'(r_s1_bias);
        for (int i = 0; i < NUM_TAPS; i++) begin
            w_sum = w_sum + ACC_W'(r_prod[i]);
        end
    end

    sat_requant #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT)
    ) u_sat_requant (
        .i_acc  (r_s2_acc),
        .o_data (w_requant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_s3_valid && out_ready) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_conv3x3_pe.sv
// Directed bench for conv3x3_pe: two instances (SHIFT=0 and SHIFT=4) share stimulus.
module tb_conv3x3_pe;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0;
    logic            in_ready, in_ready4;
    logic [8:0][7:0] ifm_in = '0;
    logic [8:0][7:0] wgt_in = '0;
    elem_t           bias_in = '0;
    logic            out_ready = 1'b0;
    logic            out_valid, out_valid4;
    elem_t           out_data, out_data4;
    logic [15:0]     out_cnt, out_cnt4;

    conv3x3_pe #(.DATA_W(8), .ACC_W(20), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ifm_in(ifm_in), .wgt_in(wgt_in), .bias_in(bias_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
    );

    conv3x3_pe #(.DATA_W(8), .ACC_W(20), .SHIFT(4)) dut_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .ifm_in(ifm_in), .wgt_in(wgt_in), .bias_in(bias_in),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_cnt(out_cnt4)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int hand_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp4_q[$];

    function automatic logic [7:0] model(input int f[9], input int w[9], input int b, input int sh);
        longint acc;
        acc = longint'(b);
        for (int i = 0; i < 9; i++) acc += longint'(f[i] * w[i]);
`ifdef CONV_PE_RELU_EN
        if (acc < 0) acc = 0;
`endif
        acc = acc >>> sh;
        if (acc > 127) acc = 127;
        else if (acc < -128) acc = -128;
        return acc[7:0];
    endfunction

    // Driver: present a window and hold it until accepted (bounded).
    task automatic push(input int f[9], input int w[9], input int b);
        int cyc;
        cyc = 0;
        for (int i = 0; i < 9; i++) begin
            ifm_in[i] = f[i][7:0];
            wgt_in[i] = w[i][7:0];
        end
        bias_in  = b[7:0];
        in_valid = 1'b1;
        #1;
        while (!in_ready && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL push_accept: in_ready=%0b required 1 after %0d cycles", in_ready, cyc);
            in_valid = 1'b0;
        end else begin
            n_pass++;
            @(posedge clk);
            exp_q.push_back(model(f, w, b, 0));
            exp4_q.push_back(model(f, w, b, 4));
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic push_u(input int f, input int w, input int b);
        int fa[9];
        int wa[9];
        for (int i = 0; i < 9; i++) begin
            fa[i] = f;
            wa[i] = w;
        end
        push(fa, wa, b);
    endtask

    task automatic wait_valid();
        int c;
        c = 0;
        #1;
        while (!out_valid && c < 20) begin
            @(negedge clk);
            #1;
            c++;
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        #3;
    endtask

    // Scoreboard: every handover is matched against the expected queues.
    always @(negedge clk) begin
        #2;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            hand_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got %0d with no result pending", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) $display("FAIL sb_data: got %0d required %0d", out_data, $signed(e));
                else n_pass++;
            end
            n_checks++;
            if (exp4_q.size() == 0) begin
                $display("FAIL sb4_unexpected: got %0d with no result pending", out_data4);
            end else begin
                logic [7:0] e4;
                e4 = exp4_q.pop_front();
                if (out_data4 !== e4) $display("FAIL sb4_data: got %0d required %0d", out_data4, $signed(e4));
                else n_pass++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", out_valid); else n_pass++;
        n_checks++; if (out_cnt !== 16'd0) $display("FAIL rst_cnt: got %0d required 0", out_cnt); else n_pass++;
        n_checks++; if (out_data !== 8'd0) $display("FAIL rst_data: got %0d required 0", out_data); else n_pass++;
        n_checks++; if (out_cnt4 !== 16'd0) $display("FAIL rst_cnt4: got %0d required 0", out_cnt4); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b required 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        @(negedge clk);
        out_ready = 1'b1;
        push_u(1, 1, 0);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL lat_c1: out_valid=%b required 0", out_valid); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL lat_c2: out_valid=%b required 0", out_valid); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL lat_c3: out_valid=%b required 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 8'sd9) $display("FAIL basic_data: got %0d required 9", out_data); else n_pass++;
        n_checks++; if (out_data4 !== 8'sd0) $display("FAIL basic_data4: got %0d required 0", out_data4); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (out_cnt !== 16'd1) $display("FAIL basic_cnt: got %0d required 1", out_cnt); else n_pass++;
    endtask

    task automatic test_saturate();
        int fa[9];
        int wa[9];
        push_u(-128, -128, 127);
        wait_valid();
        n_checks++; if (out_data !== 8'sd127) $display("FAIL sat_max: got %0d required 127", out_data); else n_pass++;
        n_checks++; if (out_data4 !== 8'sd127) $display("FAIL sat_max4: got %0d required 127", out_data4); else n_pass++;
        @(negedge clk);
        push_u(4, 4, 0);
        wait_valid();
        n_checks++; if (out_data !== 8'sd127) $display("FAIL sat_144: got %0d required 127", out_data); else n_pass++;
        n_checks++; if (out_data4 !== 8'sd9) $display("FAIL shift_144: got %0d required 9", out_data4); else n_pass++;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            fa[i] = i;
            wa[i] = i - 4;
        end
        push(fa, wa, 5);
        wait_valid();
        n_checks++; if (out_data !== 8'sd65) $display("FAIL raster: got %0d required 65", out_data); else n_pass++;
        n_checks++; if (out_data4 !== 8'sd4) $display("FAIL raster4: got %0d required 4", out_data4); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_negative();
        elem_t e0, e4, m0, m4;
`ifdef CONV_PE_RELU_EN
        e0 = 0; e4 = 0; m0 = 0; m4 = 0;
`else
        e0 = -10; e4 = -1; m0 = -128; m4 = -128;
`endif
        push_u(1, -1, -1);
        wait_valid();
        n_checks++; if (out_data !== e0) $display("FAIL neg_data: got %0d required %0d", out_data, e0); else n_pass++;
        n_checks++; if (out_data4 !== e4) $display("FAIL neg_data4: got %0d required %0d", out_data4, e4); else n_pass++;
        @(negedge clk);
        push_u(-128, 127, -128);
        wait_valid();
        n_checks++; if (out_data !== m0) $display("FAIL sat_min: got %0d required %0d", out_data, m0); else n_pass++;
        n_checks++; if (out_data4 !== m4) $display("FAIL sat_min4: got %0d required %0d", out_data4, m4); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        elem_t held;
        int h0;
        drain();
        @(negedge clk);
        out_ready = 1'b0;
        h0 = hand_cnt;
        for (int k = 1; k <= 3; k++) push_u(k, 1, 0);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL b2b_in_ready: got %b required 0", in_ready); else n_pass++;
        n_checks++; if (in_ready4 !== 1'b0) $display("FAIL b2b_in_ready4: got %b required 0", in_ready4); else n_pass++;
        n_checks++; if (out_valid4 !== 1'b1) $display("FAIL b2b_valid4: got %b required 1", out_valid4); else n_pass++;
        n_checks++; if (out_data !== 8'sd9) $display("FAIL b2b_first: got %0d required 9", out_data); else n_pass++;
        held = out_data;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0)
                $display("FAIL b2b_stall: valid=%b data=%0d in_ready=%b required 1/%0d/0", out_valid, out_data, in_ready, held);
            else n_pass++;
        end
        out_ready = 1'b1;
        for (int k = 4; k <= 6; k++) push_u(k, 1, 0);
        drain();
        n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_drain: %0d results missing required 0", exp_q.size()); else n_pass++;
        n_checks++; if (hand_cnt - h0 != 6) $display("FAIL b2b_count: got %0d handovers required 6", hand_cnt - h0); else n_pass++;
    endtask

    task automatic test_reset_flight();
        int seen;
        @(negedge clk);
        out_ready = 1'b1;
        push_u(2, 2, 0);
        push_u(3, 3, 0);
        rst = 1'b1;
        exp_q.delete();
        exp4_q.delete();
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flight_valid: got %b required 0", out_valid); else n_pass++;
        n_checks++; if (out_cnt !== 16'd0) $display("FAIL flight_cnt: got %0d required 0", out_cnt); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL flight_in_ready: got %b required 1", in_ready); else n_pass++;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL flight_stale: %0d stale results required 0", seen); else n_pass++;
    endtask

    task automatic test_wrap();
        int h0;
        h0 = hand_cnt;
        out_ready = 1'b1;
        for (int n = 0; n < 65537; n++) push_u(1, 1, n % 2);
        drain();
        n_checks++; if (hand_cnt - h0 != 65537) $display("FAIL wrap_handovers: got %0d required 65537", hand_cnt - h0); else n_pass++;
        n_checks++; if (out_cnt !== 16'd1) $display("FAIL wrap_cnt: got %0d required 1", out_cnt); else n_pass++;
        n_checks++; if (out_cnt4 !== 16'd1) $display("FAIL wrap_cnt4: got %0d required 1", out_cnt4); else n_pass++;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_negative();
        test_back_to_back();
        test_reset_flight();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
